multi_chunk_processor: RTL and testbench
========================================

MULTI_CHUNK_PROCESSOR -- requirements
Module: multi_chunk_processor

Interface
REQ-001 The block SHALL have parameter SAMPLE_SIZE, default 24, sample width in bits.
REQ-002 The block SHALL have parameter IO_BUFF_SIZE, default 64, samples per channel per chunk (power of two).
REQ-003 The block SHALL have parameter NUM_CHANNELS, default 2, channels per chunk (>=1).
REQ-004 The block SHALL have parameter START_DELAY, default 64, idle cycles between chunk_pulse and first fetch (>=1).
REQ-005 The block SHALL have derived localparams PTR_BITS=$clog2(IO_BUFF_SIZE), CH_BITS=max(1,$clog2(NUM_CHANNELS)), ADDR_BITS=CH_BITS+PTR_BITS.
REQ-006 The block SHALL have one clock; reset is synchronous and active-high: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-007 The block SHALL have ports chunk_pulse in 1, chunk start; busy out 1; done out 1, one-cycle end-of-chunk pulse.
REQ-008 The block SHALL have ports in_buff_addr out ADDR_BITS, {ch,ptr}; in_buff_sample in SAMPLE_SIZE, valid one cycle after address.
REQ-009 The block SHALL have ports out_buff_addr out ADDR_BITS; out_buff_sample out SAMPLE_SIZE; out_buff_we out 1.
REQ-010 The block SHALL have filter ports filt_in_tvalid out 1; filt_in_tready in 1; filt_in_tdata out SAMPLE_SIZE; filt_out_tvalid in 1; filt_out_tready out 1; filt_out_tdata in SAMPLE_SIZE.
REQ-011 The block SHALL have ports overrun out 1, sticky; protocol_err out 1, sticky; err_clr in 1.

Function
REQ-012 The FSM SHALL have states IDLE, DELAY, FETCH, SEND, WAIT_OUT.
REQ-013 IDLE SHALL go to DELAY on chunk_pulse, reloading the delay counter, ch=0, ptr=0.
REQ-014 DELAY SHALL last exactly START_DELAY cycles, then go to FETCH.
REQ-015 FETCH SHALL drive in_buff_addr={ch,ptr} for one cycle, then go to SEND.
REQ-016 SEND SHALL assert filt_in_tvalid with filt_in_tdata=in_buff_sample registered, held stable until filt_in_tready; on the handshake it SHALL go to WAIT_OUT.
REQ-017 WAIT_OUT SHALL assert filt_out_tready; on filt_out_tvalid it SHALL register filt_out_tdata and {ch,ptr} and assert out_buff_we for exactly one cycle on the following cycle.
REQ-018 After each output capture, ptr SHALL increment; at ptr=IO_BUFF_SIZE-1, ptr SHALL wrap to 0 and ch SHALL increment; after ch=NUM_CHANNELS-1, ptr=IO_BUFF_SIZE-1, the FSM SHALL go to IDLE and pulse done with the final out_buff_we; otherwise it SHALL go to FETCH.
REQ-019 At most one sample SHALL be in flight in the filter at any time.
REQ-020 busy SHALL be high in every state except IDLE.
REQ-021 chunk_pulse outside IDLE SHALL be ignored and SHALL set overrun.
REQ-022 filt_out_tvalid outside WAIT_OUT SHALL be ignored and SHALL set protocol_err.
REQ-023 err_clr SHALL clear both sticky flags; a simultaneous set SHALL take priority over err_clr.
REQ-024 A chunk_pulse in the same cycle as done SHALL be treated as arriving in IDLE on the next cycle only if it is still asserted then; otherwise it is an overrun.

Reset
REQ-025 rst SHALL force IDLE, ch=0, ptr=0, delay counter=0; outputs busy, done, out_buff_we, filt_in_tvalid, filt_out_tready, overrun and protocol_err SHALL be 0; addresses and data SHALL be 0.
REQ-026 rst mid-chunk SHALL abandon the chunk without a done pulse or further writes.

Configuration
REQ-027 When CHUNK_PROC_BYPASS_EN is defined, the block SHALL add an input port bypass (1 bit), sampled at chunk start; when that sample is 1, SEND SHALL skip the filter and the captured input sample SHALL be written directly to the output buffer, with filt_in_tvalid held at 0. The write SHALL use the same addressing as REQ-017 and SHALL occur one cycle after SEND.
REQ-028 When CHUNK_PROC_BYPASS_EN is undefined, the bypass port and logic SHALL be absent and behaviour SHALL be identical to bypass=0.

Structure
REQ-029 The FSM state encoding and the state-width constant SHALL reside in shared package chunk_proc_pkg.
REQ-030 The ch/ptr nested counter SHALL be sub-module chunk_addr_counter, with inputs clear and step and outputs ch, ptr and last.

Verification
REQ-031 Defaults with a filter stub that has tready=1 and 3-cycle latency, given chunk_pulse -> the first fetch occurs 64 cycles later, 128 writes to addresses 0..127, then done, then busy=0.
REQ-032 filt_in_tready held low for 10 cycles -> filt_in_tdata is stable and no writes occur until the handshake completes.
REQ-033 chunk_pulse reasserted at the 20th write -> overrun=1, the chunk completes normally, err_clr -> overrun=0.
REQ-034 filt_out_tvalid pulsed in DELAY -> protocol_err=1 and out_buff_we stays 0.
REQ-035 rst asserted after the 50th write -> no further writes, no done, busy=0; the next chunk_pulse restarts at address 0.
REQ-036 With CHUNK_PROC_BYPASS_EN defined, bypass=1, and the input ramp 0..127 -> the output buffer holds 0..127 and filt_in_tvalid is never asserted.

Source files
------------

// File: rtl/chunk_proc_pkg.sv
// -----------------------------------------------------------------------------
// chunk_proc_pkg
// Shared definitions for the multi-chunk processor: FSM state encoding, the
// state-register width and a helper for sticky error flags.
// No ports (package).
// -----------------------------------------------------------------------------
package chunk_proc_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_DELAY    = 3'd1,
        ST_FETCH    = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_OUT = 3'd4
    } state_t;

    // Sticky flag update: a new set event wins over a clear in the same cycle.
    function automatic logic sticky_next(input logic flag, input logic set, input logic clr);
        return set ? 1'b1 : (clr ? 1'b0 : flag);
    endfunction

endpackage

// File: rtl/chunk_addr_counter.sv
// -----------------------------------------------------------------------------
// chunk_addr_counter
// Nested {channel, pointer} counter walking one chunk: ptr runs 0..IO_BUFF_SIZE-1
// inside each channel, then ch advances.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   clear     - restart at ch=0, ptr=0
//   step      - advance to the next sample position
//   ch, ptr   - current position
//   last      - current position is the final sample of the chunk
// -----------------------------------------------------------------------------
module chunk_addr_counter #(
    parameter int IO_BUFF_SIZE = 64,
    parameter int NUM_CHANNELS = 2,
    parameter int PTR_BITS     = 6,
    parameter int CH_BITS      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                step,
    output logic [CH_BITS-1:0]  ch,
    output logic [PTR_BITS-1:0] ptr,
    output logic                last
);

    localparam logic [PTR_BITS-1:0] PTR_LAST = PTR_BITS'(IO_BUFF_SIZE - 1);
    localparam logic [CH_BITS-1:0]  CH_LAST  = CH_BITS'(NUM_CHANNELS - 1);

    logic [CH_BITS-1:0]  ch_q;
    logic [PTR_BITS-1:0] ptr_q;
    logic                ptr_wrap;

    assign ptr_wrap = (ptr_q == PTR_LAST);
    assign last     = ptr_wrap && (ch_q == CH_LAST);
    assign ch       = ch_q;
    assign ptr      = ptr_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            ch_q  <= '0;
            ptr_q <= '0;
        end else if (step) begin
            if (ptr_wrap) begin
                ptr_q <= '0;
                // Explicit wrap so non-power-of-two channel counts stay in range.
                ch_q  <= (ch_q == CH_LAST) ? '0 : ch_q + CH_BITS'(1);
            end else begin
                ptr_q <= ptr_q + PTR_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/multi_chunk_processor.sv
// -----------------------------------------------------------------------------
// multi_chunk_processor
// After a chunk_pulse and a fixed start delay, streams every sample of a chunk
// (NUM_CHANNELS x IO_BUFF_SIZE) from the input buffer through an external
// AXI-Stream style filter, one sample in flight at a time, and writes each
// filter result to the same {ch,ptr} address of the output buffer.
// Optional feature macro: CHUNK_PROC_BYPASS_EN adds a 'bypass' input, sampled
// at chunk start, that routes input samples straight to the output buffer.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   chunk_pulse               - start a chunk (ignored and flagged when busy)
//   busy, done                - activity flag, one-cycle end-of-chunk pulse
//   in_buff_addr/_sample      - input buffer read port (1-cycle read latency)
//   out_buff_addr/_sample/_we - output buffer write port
//   filt_in_*, filt_out_*     - filter stream interfaces
//   overrun, protocol_err     - sticky error flags, cleared by err_clr
// -----------------------------------------------------------------------------
module multi_chunk_processor
    import chunk_proc_pkg::*;
#(
    parameter  int SAMPLE_SIZE  = 24,
    parameter  int IO_BUFF_SIZE = 64,
    parameter  int NUM_CHANNELS = 2,
    parameter  int START_DELAY  = 64,
    localparam int PTR_BITS     = $clog2(IO_BUFF_SIZE),
    localparam int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int ADDR_BITS    = CH_BITS + PTR_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef CHUNK_PROC_BYPASS_EN
    input  logic                   bypass,
`endif
    input  logic                   chunk_pulse,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_BITS-1:0]   in_buff_addr,
    input  logic [SAMPLE_SIZE-1:0] in_buff_sample,
    output logic [ADDR_BITS-1:0]   out_buff_addr,
    output logic [SAMPLE_SIZE-1:0] out_buff_sample,
    output logic                   out_buff_we,
    output logic                   filt_in_tvalid,
    input  logic                   filt_in_tready,
    output logic [SAMPLE_SIZE-1:0] filt_in_tdata,
    input  logic                   filt_out_tvalid,
    output logic                   filt_out_tready,
    input  logic [SAMPLE_SIZE-1:0] filt_out_tdata,
    output logic                   overrun,
    output logic                   protocol_err,
    input  logic                   err_clr
);

    localparam int DLY_BITS = $clog2(START_DELAY + 1);

    state_t                 state_q;
    logic [DLY_BITS-1:0]    dly_q;
    logic                   load_pend_q;   // SEND cycle in which the read data arrives
    logic [SAMPLE_SIZE-1:0] tdata_q;
    logic                   tvalid_q;
    logic                   out_tready_q;
    logic [ADDR_BITS-1:0]   out_addr_q;
    logic [SAMPLE_SIZE-1:0] out_data_q;
    logic                   we_q;
    logic                   done_q;
    logic                   overrun_q;
    logic                   protocol_err_q;
    logic                   bypass_mode;

    logic [CH_BITS-1:0]     ch;
    logic [PTR_BITS-1:0]    ptr;
    logic                   last;
    logic                   start;
    logic                   capture;
    logic                   byp_capture;

`ifdef CHUNK_PROC_BYPASS_EN
    logic bypass_q;
    assign bypass_mode = bypass_q;
`else
    assign bypass_mode = 1'b0;
`endif

    // A pulse coinciding with done is not a start; it must still be high next cycle.
    assign start       = (state_q == ST_IDLE) && chunk_pulse && !done_q;
    assign capture     = (state_q == ST_WAIT_OUT) && filt_out_tvalid;
    assign byp_capture = (state_q == ST_SEND) && load_pend_q && bypass_mode;

    chunk_addr_counter #(
        .IO_BUFF_SIZE (IO_BUFF_SIZE),
        .NUM_CHANNELS (NUM_CHANNELS),
        .PTR_BITS     (PTR_BITS),
        .CH_BITS      (CH_BITS)
    ) u_addr_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .step  (capture || byp_capture),
        .ch    (ch),
        .ptr   (ptr),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            dly_q          <= '0;
            load_pend_q    <= 1'b0;
            tdata_q        <= '0;
            tvalid_q       <= 1'b0;
            out_tready_q   <= 1'b0;
            out_addr_q     <= '0;
            out_data_q     <= '0;
            we_q           <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
            protocol_err_q <= 1'b0;
`ifdef CHUNK_PROC_BYPASS_EN
            bypass_q       <= 1'b0;
`endif
        end else begin
            we_q           <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= sticky_next(overrun_q,
                                          chunk_pulse && ((state_q != ST_IDLE) || done_q),
                                          err_clr);
            protocol_err_q <= sticky_next(protocol_err_q,
                                          filt_out_tvalid && (state_q != ST_WAIT_OUT),
                                          err_clr);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q  <= ST_DELAY;
                        dly_q    <= DLY_BITS'(START_DELAY - 1);
`ifdef CHUNK_PROC_BYPASS_EN
                        bypass_q <= bypass;
`endif
                    end
                end
                ST_DELAY: begin
                    if (dly_q == '0) begin
                        state_q <= ST_FETCH;
                    end else begin
                        dly_q <= dly_q - DLY_BITS'(1);
                    end
                end
                ST_FETCH: begin
                    state_q     <= ST_SEND;
                    load_pend_q <= 1'b1;
                end
                ST_SEND: begin
                    if (load_pend_q) begin
                        load_pend_q <= 1'b0;
                        tdata_q     <= in_buff_sample;
                        if (bypass_mode) begin
                            out_data_q <= in_buff_sample;
                            out_addr_q <= {ch, ptr};
                            we_q       <= 1'b1;
                            done_q     <= last;
                            state_q    <= last ? ST_IDLE : ST_FETCH;
                        end else begin
                            tvalid_q <= 1'b1;
                        end
                    end else if (tvalid_q && filt_in_tready) begin
                        tvalid_q     <= 1'b0;
                        out_tready_q <= 1'b1;
                        state_q      <= ST_WAIT_OUT;
                    end
                end
                ST_WAIT_OUT: begin
                    if (filt_out_tvalid) begin
                        out_tready_q <= 1'b0;
                        out_data_q   <= filt_out_tdata;
                        out_addr_q   <= {ch, ptr};
                        we_q         <= 1'b1;
                        done_q       <= last;
                        state_q      <= last ? ST_IDLE : ST_FETCH;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy            = (state_q != ST_IDLE);
    assign done            = done_q;
    assign in_buff_addr    = {ch, ptr};
    assign out_buff_addr   = out_addr_q;
    assign out_buff_sample = out_data_q;
    assign out_buff_we     = we_q;
    assign filt_in_tvalid  = tvalid_q;
    assign filt_in_tdata   = tdata_q;
    assign filt_out_tready = out_tready_q;
    assign overrun         = overrun_q;
    assign protocol_err    = protocol_err_q;

endmodule

// File: tb/tb_multi_chunk_processor.sv
// -----------------------------------------------------------------------------
// tb_multi_chunk_processor
// Directed bench for multi_chunk_processor at default parameters. Models the
// input buffer (1-cycle read), a filter stub (x ^ 0x5A5A5A, 3-cycle latency)
// and the output buffer; one line is printed per chunk transaction.
// -----------------------------------------------------------------------------
module tb_multi_chunk_processor;

    localparam int SS   = 24;
    localparam int IOB  = 64;
    localparam int NCH  = 2;
    localparam int SD   = 64;
    localparam int AB   = 7;
    localparam int NW   = IOB * NCH;
    localparam int LIM  = 5000;
    localparam logic [SS-1:0] FKEY = 24'h5A5A5A;

    logic          clk = 1'b0;
    logic          rst;
    logic          bypass;
    logic          chunk_pulse;
    logic          busy, done;
    logic [AB-1:0] in_buff_addr;
    logic [SS-1:0] in_buff_sample;
    logic [AB-1:0] out_buff_addr;
    logic [SS-1:0] out_buff_sample;
    logic          out_buff_we;
    logic          filt_in_tvalid, filt_in_tready;
    logic [SS-1:0] filt_in_tdata;
    logic          filt_out_tvalid, filt_out_tready;
    logic [SS-1:0] filt_out_tdata;
    logic          overrun, protocol_err, err_clr;

    always #5 clk = ~clk;

    multi_chunk_processor dut (
        .clk             (clk),
        .rst             (rst),
`ifdef CHUNK_PROC_BYPASS_EN
        .bypass          (bypass),
`endif
        .chunk_pulse     (chunk_pulse),
        .busy            (busy),
        .done            (done),
        .in_buff_addr    (in_buff_addr),
        .in_buff_sample  (in_buff_sample),
        .out_buff_addr   (out_buff_addr),
        .out_buff_sample (out_buff_sample),
        .out_buff_we     (out_buff_we),
        .filt_in_tvalid  (filt_in_tvalid),
        .filt_in_tready  (filt_in_tready),
        .filt_in_tdata   (filt_in_tdata),
        .filt_out_tvalid (filt_out_tvalid),
        .filt_out_tready (filt_out_tready),
        .filt_out_tdata  (filt_out_tdata),
        .overrun         (overrun),
        .protocol_err    (protocol_err),
        .err_clr         (err_clr)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int exp_addr = 0;
    int wr_cnt   = 0;
    int done_cnt = 0;
    logic exp_byp  = 1'b0;
    logic tv_seen  = 1'b0;
    logic viol_one = 1'b0;

    logic [SS-1:0] in_mem  [0:NW-1];
    logic [SS-1:0] out_mem [0:NW-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- input buffer: registered read ----------------
    always @(posedge clk) in_buff_sample <= in_mem[in_buff_addr];

    // ---------------- filter stub ----------------
    logic          filt_ready = 1'b1;
    logic          inj = 1'b0;
    logic          pend = 1'b0;
    logic [1:0]    lat  = 2'd0;
    logic [SS-1:0] hold = '0;

    assign filt_in_tready  = filt_ready;
    assign filt_out_tvalid = (pend && lat == 2'd0) || inj;
    assign filt_out_tdata  = hold;

    always @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else if (filt_in_tvalid && filt_in_tready) begin
            pend <= 1'b1;
            lat  <= 2'd3;
            hold <= filt_in_tdata ^ FKEY;
        end else if (pend && lat != 2'd0) begin
            lat <= lat - 2'd1;
        end else if (pend && filt_out_tready) begin
            pend <= 1'b0;
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (filt_in_tvalid) tv_seen = 1'b1;
        if (filt_in_tvalid && pend) viol_one = 1'b1;
        if (out_buff_we) begin
            check("wr_addr", 32'(out_buff_addr), 32'(exp_addr));
            check("wr_data", 32'(out_buff_sample),
                  32'(exp_byp ? in_mem[exp_addr] : (in_mem[exp_addr] ^ FKEY)));
            out_mem[out_buff_addr] = out_buff_sample;
            exp_addr++;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            check("done_wcnt", 32'(wr_cnt), 32'(NW));
            check("done_we", 32'(out_buff_we), 32'd1);
        end
    end

    // ---------------- helpers ----------------
    task automatic start_chunk();
        @(negedge clk);
        exp_addr    = 0;
        wr_cnt      = 0;
        chunk_pulse = 1'b1;
        @(posedge clk);
        #1 chunk_pulse = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < LIM) begin
            @(negedge clk);
            #1 n++;
        end
        check("done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic wait_writes(input int target);
        int n = 0;
        while (wr_cnt < target && n < LIM) begin
            @(negedge clk);
            #1 n++;
        end
        check("write_timeout", 32'(wr_cnt >= target), 32'd1);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int d0;
        logic [SS-1:0] first;
        rst = 1'b1; chunk_pulse = 1'b0; err_clr = 1'b0; bypass = 1'b0;
        for (int i = 0; i < NW; i++) in_mem[i] = SS'(32'h100000 + i * 855);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_we",       32'(out_buff_we), 32'd0);
        check("rst_tvalid",   32'(filt_in_tvalid), 32'd0);
        check("rst_tready",   32'(filt_out_tready), 32'd0);
        check("rst_overrun",  32'(overrun), 32'd0);
        check("rst_perr",     32'(protocol_err), 32'd0);
        check("rst_in_addr",  32'(in_buff_addr), 32'd0);
        check("rst_out_addr", 32'(out_buff_addr), 32'd0);
        check("rst_out_data", 32'(out_buff_sample), 32'd0);
        check("rst_tdata",    32'(filt_in_tdata), 32'd0);
        rst = 1'b0;

        // 1: start delay and a full chunk
        d0 = done_cnt;
        start_chunk();
        check("busy_after_pulse", 32'(busy), 32'd1);
        k = 0;
        while (!filt_in_tvalid && k < 200) begin
            @(posedge clk);
            #1 k++;
        end
        // FETCH at +SD, read data lands in SEND at +SD+1, tvalid at +SD+2
        check("first_tvalid_latency", 32'(k), 32'(SD + 2));
        wait_done(d0 + 1);
        @(negedge clk);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        $display("chunk normal: writes=%0d done=%0d", wr_cnt, done_cnt);

        // 2: filter stalls input side for 10 cycles
        filt_ready = 1'b0;
        d0 = done_cnt;
        start_chunk();
        k = 0;
        while (!filt_in_tvalid && k < 200) begin
            @(negedge clk);
            k++;
        end
        first = in_mem[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_tvalid", 32'(filt_in_tvalid), 32'd1);
            check("stall_tdata",  32'(filt_in_tdata), 32'(first));
            check("stall_nowr",   32'(wr_cnt), 32'd0);
        end
        filt_ready = 1'b1;
        wait_done(d0 + 1);
        $display("chunk stall: writes=%0d done=%0d", wr_cnt, done_cnt);

        // 3: chunk_pulse while busy -> overrun, chunk still completes
        d0 = done_cnt;
        start_chunk();
        wait_writes(20);
        @(negedge clk);
        chunk_pulse = 1'b1;
        @(posedge clk);
        #1 chunk_pulse = 1'b0;
        check("overrun_set", 32'(overrun), 32'd1);
        wait_done(d0 + 1);
        repeat (SD / 2) @(negedge clk);
        check("overrun_no_restart", 32'(busy), 32'd0);
        check("overrun_held", 32'(overrun), 32'd1);
        pulse_err_clr();
        check("overrun_clr", 32'(overrun), 32'd0);
        $display("chunk overrun: writes=%0d done=%0d", wr_cnt, done_cnt);

        // 4: stray filter output during DELAY
        d0 = done_cnt;
        start_chunk();
        repeat (5) @(negedge clk);
        inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        check("perr_set", 32'(protocol_err), 32'd1);
        @(negedge clk);
        check("perr_no_we", 32'(out_buff_we), 32'd0);
        check("perr_no_wr", 32'(wr_cnt), 32'd0);
        wait_done(d0 + 1);
        pulse_err_clr();
        check("perr_clr", 32'(protocol_err), 32'd0);
        $display("chunk protocol_err: writes=%0d done=%0d", wr_cnt, done_cnt);

        // 5: reset mid-chunk, then a fresh chunk from address 0
        d0 = done_cnt;
        start_chunk();
        wait_writes(50);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (300) @(negedge clk);
        check("rst_mid_writes", 32'(wr_cnt), 32'd50);
        check("rst_mid_nodone", 32'(done_cnt), 32'(d0));
        check("rst_mid_busy",   32'(busy), 32'd0);
        $display("chunk reset: writes=%0d done=%0d", wr_cnt, done_cnt);
        start_chunk();
        wait_done(d0 + 1);
        $display("chunk restart: writes=%0d done=%0d", wr_cnt, done_cnt);

`ifdef CHUNK_PROC_BYPASS_EN
        // 6: bypass with a ramp input
        for (int i = 0; i < NW; i++) in_mem[i] = SS'(i);
        bypass  = 1'b1;
        exp_byp = 1'b1;
        tv_seen = 1'b0;
        d0 = done_cnt;
        start_chunk();
        #1 bypass = 1'b0;
        wait_done(d0 + 1);
        check("byp_no_tvalid", 32'(tv_seen), 32'd0);
        for (int i = 0; i < NW; i++) check("byp_mem", 32'(out_mem[i]), 32'(i));
        exp_byp = 1'b0;
        $display("chunk bypass: writes=%0d done=%0d", wr_cnt, done_cnt);
`endif

        check("one_in_flight", 32'(viol_one), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
